// File: rtl/uart_pkg.sv
// Shared types for the UART transmit-side scheduler: FSM encoding, byte width
// and the two-way round-robin grant helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_sched_state_t;

  // A lone requester always wins; on contention the pointer names the winner.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic ptr);
    logic [1:0] g;
    g = 2'b00;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = ptr ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO feeding the UART scheduler; simultaneous push and pop
// leave the count unchanged, pointers wrap naturally (depth is a power of two).
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [UART_DATA_W-1:0]        din,
  output logic [UART_DATA_W-1:0]        dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [UART_DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   push_ok;
  logic                   pop_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: round-robin arbitration of two byte sources into a FIFO,
// then the UART load / start / busy handshake for each queued byte.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [1:0]                   req_valid,
  input  logic [UART_DATA_W-1:0]       req_data0,
  input  logic [UART_DATA_W-1:0]       req_data1,
  output logic [1:0]                   req_ready,
  output logic [UART_DATA_W-1:0]       uart_data,
  output logic                         uart_byte_ready,
  output logic                         uart_tx_byte,
  input  logic                         uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         sched_idle,
  output logic                         start_err
);

  localparam int TW = $clog2(START_TIMEOUT) + 1;

  tx_sched_state_t        state;
  tx_sched_state_t        state_nxt;
  logic                   rr_ptr;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push_sel;
  logic [UART_DATA_W-1:0] push_data;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic [TW-1:0]          tmo_cnt;
  logic                   tmo_hit;

  // Full comes from the registered count, so a pop this cycle never frees a slot early.
  always_comb begin
    req_ready = 2'b00;
    if (!fifo_full) req_ready = rr_grant(req_valid, rr_ptr);
  end

  assign fifo_push = |(req_valid & req_ready);
  assign push_sel  = req_ready[1];
  assign push_data = push_sel ? req_data1 : req_data0;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)         rr_ptr <= 1'b0;
    else if (fifo_push) rr_ptr <= ~push_sel;
  end

  uart_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // tmo_cnt is 0 on the first WAIT_BUSY cycle, i.e. one cycle after tx_byte, so
  // firing at START_TIMEOUT-2 makes start_err visible START_TIMEOUT cycles after
  // the strobe (START_TIMEOUT must be at least 2).
  assign tmo_hit = (state == WAIT_BUSY) && !uart_tx_busy &&
                   (tmo_cnt == TW'(START_TIMEOUT - 2));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!fifo_empty && !uart_tx_busy) state_nxt = LOAD;
      LOAD:      state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart_tx_busy) state_nxt = WAIT_DONE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (!uart_tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    uart_byte_ready = (state == LOAD);
    uart_tx_byte    = (state == START);
    fifo_pop        = (state == IDLE) && !fifo_empty && !uart_tx_busy;
    sched_idle      = (state == IDLE) && fifo_empty;
  end

  // uart_data changes only on a pop, so it stays stable for the whole transfer.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      uart_data <= '0;
      tmo_cnt   <= '0;
      start_err <= 1'b0;
    end else begin
      if (fifo_pop) uart_data <= fifo_dout;
      if (state == START)          tmo_cnt <= '0;
      else if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit) start_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-fed byte sources, a behavioural UART busy model,
// and a scoreboard monitor tracking queue order, occupancy and arbitration.
module tb_uart_tx_sched;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       CLK;
  logic       reset;
  logic [1:0] req_valid;
  logic [7:0] req_data0, req_data1;
  logic [1:0] req_ready;
  logic [7:0] uart_data;
  logic       uart_byte_ready, uart_tx_byte, uart_tx_busy;
  logic [2:0] fifo_count;
  logic       sched_idle, start_err;

  logic       model_busy, force_busy;
  assign uart_tx_busy = model_busy | force_busy;

  uart_tx_sched #(.FIFO_DEPTH(DEPTH), .START_TIMEOUT(TMO)) dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_ready(req_ready), .uart_data(uart_data),
    .uart_byte_ready(uart_byte_ready), .uart_tx_byte(uart_tx_byte),
    .uart_tx_busy(uart_tx_busy), .fifo_count(fifo_count),
    .sched_idle(sched_idle), .start_err(start_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int sent = 0;
  int frame = 20;
  int gate = 100;
  bit busy_en = 1;
  logic [1:0] acc = 2'b00;
  logic [7:0] src0_q[$], src1_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_log[$];
  int         acc_log[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_neg();
    @(negedge CLK);
    #1;
  endtask

  function automatic bit cond(input int w);
    case (w)
      0: return uart_byte_ready;
      1: return uart_tx_byte;
      2: return uart_tx_busy;
      3: return !uart_tx_busy;
      4: return start_err;
      5: return fifo_count == 3'(DEPTH);
      6: return fifo_count == 3'd3;
      7: return sched_idle && !uart_tx_busy && req_valid == 2'b00 &&
                src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0;
      8: return fifo_count == 3'd2 && req_valid == 2'b00 && src0_q.size() == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int budget, input string name);
    int n = 0;
    wait_neg();
    while (!cond(w) && n < budget) begin
      wait_neg();
      n++;
    end
    if (!cond(w)) begin
      checks++;
      errors++;
      $display("FAIL %s: timed out after %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #3;
    reset = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    reset = 1'b1;
  endtask

  // Byte sources: a raised valid is held with stable data until it is accepted.
  initial begin
    logic nv0, nv1;
    req_valid = 2'b00;
    req_data0 = 8'h00;
    req_data1 = 8'h00;
    forever begin
      @(posedge CLK); #1;
      if (!reset) begin
        req_valid = 2'b00;
      end else begin
        if (acc[0] && src0_q.size() > 0) void'(src0_q.pop_front());
        if (acc[1] && src1_q.size() > 0) void'(src1_q.pop_front());
        nv0 = req_valid[0] && !acc[0] && src0_q.size() > 0;
        nv1 = req_valid[1] && !acc[1] && src1_q.size() > 0;
        if (!nv0 && src0_q.size() > 0 && $urandom_range(0, 99) < gate) nv0 = 1'b1;
        if (!nv1 && src1_q.size() > 0 && $urandom_range(0, 99) < gate) nv1 = 1'b1;
        req_valid = {nv1, nv0};
        if (nv0) req_data0 = src0_q[0];
        if (nv1) req_data1 = src1_q[0];
      end
    end
  end

  // UART model: busy rises the cycle after tx_byte and stays high for `frame` cycles.
  initial begin
    int  busy_cnt = 0;
    bit  txs;
    model_busy = 1'b0;
    forever begin
      @(negedge CLK);
      txs = uart_tx_byte;
      @(posedge CLK); #1;
      if (!reset) busy_cnt = 0;
      else if (busy_cnt > 0) busy_cnt--;
      else if (txs && busy_en) busy_cnt = frame;
      model_busy = (busy_cnt > 0);
    end
  end

  // Monitor / reference model: occupancy = accepted - launched, round-robin
  // pointer flips to the other requester after each acceptance.
  initial begin
    int   mcount = 0;
    bit   pend = 0;
    bit   rr = 0;
    bit   prev_br = 0;
    bit   full;
    int   i;
    logic [1:0] er;
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!reset) begin
        mcount = 0; pend = 0; rr = 0; prev_br = 0; acc = 2'b00;
        exp_q.delete();
      end else begin
        mcount += int'(pend);
        pend = 0;
        if (uart_byte_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_byte", int'(uart_data), -1);
          end else begin
            e = exp_q.pop_front();
            check(uart_data == e, "uart_data", int'(uart_data), int'(e));
            obs_log.push_back(uart_data);
            sent++;
          end
          mcount--;
        end
        check(int'(fifo_count) == mcount, "fifo_count", int'(fifo_count), mcount);
        if (uart_byte_ready || uart_tx_byte || prev_br)
          check(!(uart_byte_ready && uart_tx_byte) && (uart_tx_byte == prev_br),
                "strobe_seq", {uart_byte_ready, uart_tx_byte}, {1'b0, prev_br});
        full = (mcount >= DEPTH);
        er = 2'b00;
        if (!full) begin
          if (req_valid == 2'b01) er = 2'b01;
          else if (req_valid == 2'b10) er = 2'b10;
          else if (req_valid == 2'b11) er = rr ? 2'b10 : 2'b01;
        end
        check(req_ready == er, "req_ready", int'(req_ready), int'(er));
        acc = req_valid & req_ready;
        if (acc != 2'b00) begin
          i = acc[1] ? 1 : 0;
          exp_q.push_back(i == 1 ? req_data1 : req_data0);
          rr = (i == 0);
          pend = 1;
          acc_cyc = cyc;
          acc_log.push_back(i);
        end
        prev_br = uart_byte_ready;
      end
    end
  end

  initial begin
    int t0, s0, bad;
    logic [7:0] b;
    logic [7:0] exp2 [4];
    int         exp_acc [4];
    exp2 = '{8'hA0, 8'h50, 8'hA1, 8'h51};
    exp_acc = '{0, 1, 0, 1};
    reset = 1'b0;
    force_busy = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check(uart_data == 8'h00, "rst_uart_data", int'(uart_data), 0);
    check(uart_byte_ready == 1'b0, "rst_byte_ready", int'(uart_byte_ready), 0);
    check(uart_tx_byte == 1'b0, "rst_tx_byte", int'(uart_tx_byte), 0);
    check(start_err == 1'b0, "rst_start_err", int'(start_err), 0);
    check(fifo_count == 3'd0, "rst_fifo_count", int'(fifo_count), 0);
    check(sched_idle == 1'b1, "rst_sched_idle", int'(sched_idle), 1);
    @(posedge CLK); #3;
    reset = 1'b1;

    // single byte latency and busy tracking
    frame = 20;
    wait_neg();
    src0_q.push_back(8'hB2);
    wait_sig(0, 50, "t1_byte_ready");
    check(cyc - acc_cyc == 2, "t1_br_latency", cyc - acc_cyc, 2);
    check(uart_data == 8'hB2, "t1_uart_data", int'(uart_data), 8'hB2);
    wait_neg();
    check(uart_tx_byte == 1'b1, "t1_tx_byte", int'(uart_tx_byte), 1);
    wait_sig(2, 20, "t1_busy_rise");
    wait_sig(3, 40, "t1_busy_fall");
    check(sched_idle == 1'b0, "t1_idle_busyfall", int'(sched_idle), 0);
    wait_neg();
    check(sched_idle == 1'b1, "t1_idle_after", int'(sched_idle), 1);

    // contention alternates starting with requester 0
    do_reset();
    frame = 4;
    wait_neg();
    obs_log.delete();
    acc_log.delete();
    src0_q.push_back(8'hA0); src0_q.push_back(8'hA1);
    src1_q.push_back(8'h50); src1_q.push_back(8'h51);
    wait_sig(7, 200, "t2_drain");
    check(obs_log.size() == 4 && acc_log.size() == 4, "t2_count", obs_log.size(), 4);
    for (int k = 0; k < 4 && k < obs_log.size() && k < acc_log.size(); k++) begin
      check(obs_log[k] == exp2[k], "t2_uart_order", int'(obs_log[k]), int'(exp2[k]));
      check(acc_log[k] == exp_acc[k], "t2_accept_order", acc_log[k], exp_acc[k]);
    end

    // FIFO full with busy held high while idle
    force_busy = 1'b1;
    s0 = sent;
    for (int k = 0; k < 5; k++) src0_q.push_back(8'($urandom));
    wait_sig(5, 40, "t3_fill");
    wait_neg();
    check(req_ready == 2'b00 && req_valid[0], "t3_full_ready", {req_valid, req_ready}, 4'b0100);
    repeat (3) wait_neg();
    check(fifo_count == 3'(DEPTH), "t3_hold_count", int'(fifo_count), DEPTH);
    force_busy = 1'b0;
    wait_sig(7, 400, "t3_drain");
    check(sent - s0 == 5, "t3_sent", sent - s0, 5);

    // push and pop in the same cycle at count 2
    force_busy = 1'b1;
    src0_q.push_back(8'($urandom)); src0_q.push_back(8'($urandom));
    wait_sig(8, 40, "t4_fill2");
    src0_q.push_back(8'($urandom));
    @(posedge CLK); #2;
    force_busy = 1'b0;
    wait_neg();
    check(req_ready == 2'b01, "t4_push_ready", int'(req_ready), 1);
    wait_neg();
    check(fifo_count == 3'd2, "t4_pp_count", int'(fifo_count), 2);
    wait_sig(7, 400, "t4_drain");

    // start timeout, then recovery
    busy_en = 1'b0;
    src0_q.push_back(8'hC3); src0_q.push_back(8'($urandom));
    wait_sig(1, 40, "t5_tx_byte");
    t0 = cyc;
    wait_sig(4, 40, "t5_start_err");
    check(cyc - t0 == TMO, "t5_err_latency", cyc - t0, TMO);
    busy_en = 1'b1;
    wait_neg();
    check(uart_byte_ready == 1'b1, "t5_next_load", int'(uart_byte_ready), 1);
    wait_sig(7, 200, "t5_drain");
    check(start_err == 1'b1, "t5_err_sticky", int'(start_err), 1);

    // reset mid-frame with bytes queued
    frame = 40;
    for (int k = 0; k < 4; k++) src0_q.push_back(8'($urandom));
    wait_sig(2, 40, "t6_busy");
    wait_sig(6, 40, "t6_queued3");
    @(posedge CLK); #3;
    reset = 1'b0;
    #1;
    check(uart_data == 8'h00, "t6_uart_data", int'(uart_data), 0);
    check(uart_byte_ready == 1'b0, "t6_byte_ready", int'(uart_byte_ready), 0);
    check(uart_tx_byte == 1'b0, "t6_tx_byte", int'(uart_tx_byte), 0);
    check(start_err == 1'b0, "t6_start_err", int'(start_err), 0);
    check(fifo_count == 3'd0, "t6_fifo_count", int'(fifo_count), 0);
    check(sched_idle == 1'b1, "t6_sched_idle", int'(sched_idle), 1);
    src0_q.delete();
    src1_q.delete();
    repeat (3) @(posedge CLK);
    #3;
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      wait_neg();
      if (uart_byte_ready || uart_tx_byte) bad++;
    end
    check(bad == 0, "t6_no_strobes", bad, 0);

    // randomized traffic
    for (int r = 0; r < 4; r++) begin
      frame = $urandom_range(2, 12);
      gate = $urandom_range(30, 100);
      s0 = sent;
      t0 = $urandom_range(6, 14);
      for (int k = 0; k < t0; k++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 1) == 1) src1_q.push_back(b);
        else src0_q.push_back(b);
      end
      wait_sig(7, 3000, "rand_drain");
      check(sent - s0 == t0, "rand_sent", sent - s0, t0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
